// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receiver: FSM state encoding, parity codes, level names.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    RX_IDLE   = 3'd0,
    RX_START  = 3'd1,
    RX_DATA   = 3'd2,
    RX_PARITY = 3'd3,
    RX_STOP   = 3'd4
  } rx_state_t;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  localparam logic HIGH = 1'b1;
  localparam logic LOW  = 1'b0;

  // Counter width for values 0..v-1, never narrower than one bit.
  function automatic int clog2_min1(input int v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Multi-stage synchronizer bringing the asynchronous rx pin into the clk domain.
// Latency: STAGES clk cycles.
// Backpressure: none; samples every clk. Resets to 1 so an idle line never looks like a start bit.
module uart_rx_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_ff;

  // Shift the raw line through the flop chain; preset to the idle level on reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_ff <= '1;
    end else begin
      sync_ff <= {sync_ff[STAGES-2:0], d};
    end
  end

  assign q = sync_ff[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// UART receiver: recovers start/data(LSB first)/optional parity/stop from rx using s_tick oversampling.
// Latency: rx_done rises one clk after the final stop-region s_tick; dout/flags then hold until next frame.
// Backpressure: none; rx_done is a one-cycle strobe the consumer must take when it fires.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int DATA_BITS    = 8,
  parameter int OVERSAMPLING = 16,
  parameter int SB_TICKS     = 16,
  parameter int PARITY       = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  input  logic                 s_tick,
  output logic [DATA_BITS-1:0] dout,
  output logic                 rx_done,
  output logic                 frame_error,
  output logic                 parity_error,
  output logic                 busy
);

  localparam int TICK_MAX = (OVERSAMPLING > SB_TICKS) ? OVERSAMPLING : SB_TICKS;
  localparam int TICK_W   = clog2_min1(TICK_MAX);
  localparam int BIT_W    = clog2_min1(DATA_BITS);

  localparam logic [TICK_W-1:0] TICK_MID  = TICK_W'(OVERSAMPLING / 2 - 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLING - 1);
  localparam logic [TICK_W-1:0] STOP_LAST = TICK_W'(SB_TICKS - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);
  localparam logic              PAR_ODD   = (PARITY == PARITY_ODD);

  logic rx_s;

  rx_state_t            state_q, state_d;
  logic [TICK_W-1:0]    tick_q, tick_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 par_bad_q, par_bad_d;
  logic [DATA_BITS-1:0] dout_q, dout_d;
  logic                 fe_q, fe_d;
  logic                 pe_q, pe_d;
  logic                 done_q, done_d;

  uart_rx_sync #(
    .STAGES (2)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rx),
    .q     (rx_s)
  );

  // Frame state, counters, shift register and held result registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= RX_IDLE;
      tick_q    <= '0;
      bit_q     <= '0;
      shreg_q   <= '0;
      par_bad_q <= LOW;
      dout_q    <= '0;
      fe_q      <= LOW;
      pe_q      <= LOW;
      done_q    <= LOW;
    end else begin
      state_q   <= state_d;
      tick_q    <= tick_d;
      bit_q     <= bit_d;
      shreg_q   <= shreg_d;
      par_bad_q <= par_bad_d;
      dout_q    <= dout_d;
      fe_q      <= fe_d;
      pe_q      <= pe_d;
      done_q    <= done_d;
    end
  end

  // Next-state logic: counters move only on s_tick; IDLE reacts to the line directly.
  always_comb begin
    state_d   = state_q;
    tick_d    = tick_q;
    bit_d     = bit_q;
    shreg_d   = shreg_q;
    par_bad_d = par_bad_q;
    dout_d    = dout_q;
    fe_d      = fe_q;
    pe_d      = pe_q;
    done_d    = LOW;

    case (state_q)
      RX_IDLE: begin
        if (rx_s == LOW) begin
          state_d = RX_START;
          tick_d  = '0;
        end
      end

      RX_START: begin
        if (s_tick) begin
          if (tick_q == TICK_MID) begin
            if (rx_s == LOW) begin
              state_d   = RX_DATA;
              tick_d    = '0;
              bit_d     = '0;
              par_bad_d = LOW;
            end else begin
              // Line was high again by mid start bit: treat as noise.
              state_d = RX_IDLE;
            end
          end else begin
            tick_d = tick_q + TICK_W'(1);
          end
        end
      end

      RX_DATA: begin
        if (s_tick) begin
          if (tick_q == TICK_LAST) begin
            tick_d  = '0;
            shreg_d = {rx_s, shreg_q[DATA_BITS-1:1]};
            if (bit_q == BIT_LAST) begin
              state_d = (PARITY != PARITY_NONE) ? RX_PARITY : RX_STOP;
            end else begin
              bit_d = bit_q + BIT_W'(1);
            end
          end else begin
            tick_d = tick_q + TICK_W'(1);
          end
        end
      end

      RX_PARITY: begin
        if (s_tick) begin
          if (tick_q == TICK_LAST) begin
            // Odd parity wants an odd total of ones over data+parity, even wants even.
            par_bad_d = ((^shreg_q) ^ rx_s) != PAR_ODD;
            state_d   = RX_STOP;
            tick_d    = '0;
          end else begin
            tick_d = tick_q + TICK_W'(1);
          end
        end
      end

      RX_STOP: begin
        if (s_tick) begin
          if (tick_q == STOP_LAST) begin
            state_d = RX_IDLE;
            dout_d  = shreg_q;
            fe_d    = ~rx_s;
            pe_d    = par_bad_q;
            done_d  = HIGH;
          end else begin
            tick_d = tick_q + TICK_W'(1);
          end
        end
      end

      default: begin
        state_d = RX_IDLE;
      end
    endcase
  end

  assign dout         = dout_q;
  assign rx_done      = done_q;
  assign frame_error  = fe_q;
  assign parity_error = pe_q;
  assign busy         = (state_q != RX_IDLE);

endmodule
